// File: rtl/key_scanner.sv
// 4x4 keypad matrix scanner with debounce; emits key_in/key_val/key_strobe events.
// Optional auto-repeat of key_strobe while held: define KEY_SCANNER_REPEAT_EN.
module key_scanner #(
    parameter int unsigned SCAN_DIV       = 1000,
    parameter int unsigned DEBOUNCE_SCANS = 4,
    parameter int unsigned REPEAT_DELAY   = 64,
    parameter int unsigned REPEAT_RATE    = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] col_in,
    output logic [3:0] row_out,
    output logic       key_in,
    output logic [3:0] key_val,
    output logic       key_strobe
);

    localparam int unsigned DWELL_W = $clog2(SCAN_DIV);
    localparam int unsigned CNT_W   = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0]   CNT_LAST   = CNT_W'(DEBOUNCE_SCANS - 1);

    // Elaboration-time guard against unusable parameter values
    if (SCAN_DIV < 2 || DEBOUNCE_SCANS < 1 || REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_param_check
        $error("key_scanner: invalid parameter value");
    end

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HOLD     = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [DWELL_W-1:0] dwell;
    logic [1:0]         row;
    logic [1:0]         row_nxt;
    logic [1:0]         col;
    logic [1:0]         col_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_nxt;
    logic [CNT_W-1:0]   rel;
    logic [CNT_W-1:0]   rel_nxt;
    logic [3:0]         row_out_nxt;
    logic               key_in_nxt;
    logic [3:0]         key_val_nxt;
    logic               key_strobe_nxt;
    logic [1:0]         low_col;
    logic               sample;
    logic               any_low;
    logic               cap_low;

    assign sample  = (dwell == DWELL_LAST);
    assign any_low = (col_in != 4'hF);
    assign cap_low = ~col_in[col];

    // Lowest-index active column wins when several are low
    always_comb begin
        low_col = 2'd0;
        for (int c = 3; c >= 0; c--) begin
            if (!col_in[c]) begin
                low_col = 2'(c);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            dwell <= '0;
        end else if (sample) begin
            dwell <= '0;
        end else begin
            dwell <= dwell + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= SCAN;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            SCAN: begin
                if (sample && any_low) begin
                    state_nxt = DEBOUNCE;
                end
            end
            DEBOUNCE: begin
                if (sample) begin
                    if (!cap_low) begin
                        state_nxt = SCAN;
                    end else if (cnt == CNT_LAST) begin
                        state_nxt = HOLD;
                    end
                end
            end
            HOLD: begin
                if (sample && !cap_low && rel == CNT_LAST) begin
                    state_nxt = SCAN;
                end
            end
            default: state_nxt = SCAN;
        endcase
    end

`ifdef KEY_SCANNER_REPEAT_EN
    localparam int unsigned REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int unsigned REP_W   = $clog2(REP_MAX + 1);
    localparam logic [REP_W-1:0] REP_DELAY_LAST = REP_W'(REPEAT_DELAY - 1);
    localparam logic [REP_W-1:0] REP_RATE_LAST  = REP_W'(REPEAT_RATE - 1);

    logic [REP_W-1:0] rep_cnt;
    logic [REP_W-1:0] rep_cnt_nxt;
    logic             rep_armed;
    logic             rep_armed_nxt;
    logic             rep_fire;

    // First repeat after REPEAT_DELAY held samples, then every REPEAT_RATE
    always_comb begin
        rep_cnt_nxt   = rep_cnt;
        rep_armed_nxt = rep_armed;
        rep_fire      = 1'b0;
        if (state != HOLD) begin
            rep_cnt_nxt   = '0;
            rep_armed_nxt = 1'b0;
        end else if (sample) begin
            if (!cap_low) begin
                rep_cnt_nxt   = '0;
                rep_armed_nxt = 1'b0;
            end else if (rep_cnt == (rep_armed ? REP_RATE_LAST : REP_DELAY_LAST)) begin
                rep_fire      = 1'b1;
                rep_cnt_nxt   = '0;
                rep_armed_nxt = 1'b1;
            end else begin
                rep_cnt_nxt = rep_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rep_cnt   <= '0;
            rep_armed <= 1'b0;
        end else begin
            rep_cnt   <= rep_cnt_nxt;
            rep_armed <= rep_armed_nxt;
        end
    end
`else
    logic rep_fire;
    assign rep_fire = 1'b0;
`endif

    // Next values of the scan datapath and registered outputs
    always_comb begin
        row_nxt        = row;
        col_nxt        = col;
        cnt_nxt        = cnt;
        rel_nxt        = rel;
        key_in_nxt     = key_in;
        key_val_nxt    = key_val;
        key_strobe_nxt = rep_fire;
        case (state)
            SCAN: begin
                if (sample) begin
                    if (any_low) begin
                        col_nxt = low_col;
                        cnt_nxt = '0;
                    end else begin
                        row_nxt = row + 2'd1;
                    end
                end
            end
            DEBOUNCE: begin
                if (sample) begin
                    if (!cap_low) begin
                        row_nxt = row + 2'd1;
                    end else if (cnt == CNT_LAST) begin
                        key_in_nxt     = 1'b1;
                        key_val_nxt    = {row, col};
                        key_strobe_nxt = 1'b1;
                        rel_nxt        = '0;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
            end
            HOLD: begin
                if (sample) begin
                    if (cap_low) begin
                        rel_nxt = '0;
                    end else if (rel == CNT_LAST) begin
                        key_in_nxt = 1'b0;
                        row_nxt    = row + 2'd1;
                    end else begin
                        rel_nxt = rel + 1'b1;
                    end
                end
            end
            default: begin
                row_nxt = 2'd0;
            end
        endcase
        row_out_nxt = 4'(~(4'b0001 << row_nxt));
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            row        <= 2'd0;
            col        <= 2'd0;
            cnt        <= '0;
            rel        <= '0;
            row_out    <= 4'b1110;
            key_in     <= 1'b0;
            key_val    <= 4'h0;
            key_strobe <= 1'b0;
        end else begin
            row        <= row_nxt;
            col        <= col_nxt;
            cnt        <= cnt_nxt;
            rel        <= rel_nxt;
            row_out    <= row_out_nxt;
            key_in     <= key_in_nxt;
            key_val    <= key_val_nxt;
            key_strobe <= key_strobe_nxt;
        end
    end

endmodule
